// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// Debounced 4x4 matrix keypad scanner: rotates the column drive, debounces the
// synchronized rows and emits one registered pulse per accepted key press.
module keypad_scanner #(
  parameter int NUM_SCAN       = 50000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       start,
  output logic       clear
);

  localparam int WW = $clog2(NUM_SCAN);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(NUM_SCAN - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state, state_n;
  logic [3:0]    row_meta, rs;
  logic [WW-1:0] win;
  logic [3:0]    col_n, lrow, lrow_n;
  logic [CW-1:0] cnt, cnt_n, rcnt, rcnt_n;
  logic          accept, accept_n;
  logic [3:0]    key_value_n;
  logic          key_valid_n, start_n, clear_n;
  logic          sample, one_low;
  logic [1:0]    ri, ci;
  logic [3:0]    col_rot;

  assign sample  = (win == WIN_LAST);
  assign one_low = (rs == 4'b1110) || (rs == 4'b1101) ||
                   (rs == 4'b1011) || (rs == 4'b0111);
  assign col_rot = {col[2:0], col[3]};

  // rst_n is an active-high reset despite its name.
  // NOTE: every clocked register below uses <= so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      row_meta  <= 4'hF;
      rs        <= 4'hF;
      win       <= '0;
      state     <= SCAN;
      col       <= 4'b1110;
      lrow      <= 4'hF;
      cnt       <= '0;
      rcnt      <= '0;
      accept    <= 1'b0;
      key_value <= 4'd0;
      key_valid <= 1'b0;
      start     <= 1'b0;
      clear     <= 1'b0;
    end else begin
      row_meta  <= row;
      rs        <= row_meta;
      win       <= sample ? '0 : win + WW'(1);
      state     <= state_n;
      col       <= col_n;
      lrow      <= lrow_n;
      cnt       <= cnt_n;
      rcnt      <= rcnt_n;
      accept    <= accept_n;
      key_value <= key_value_n;
      key_valid <= key_valid_n;
      start     <= start_n;
      clear     <= clear_n;
    end
  end

  // NOTE: every signal gets a default first, so no path through this block infers a latch.
  always_comb begin
    state_n  = state;
    col_n    = col;
    lrow_n   = lrow;
    cnt_n    = cnt;
    rcnt_n   = rcnt;
    accept_n = 1'b0;
    if (sample) begin
      case (state)
        SCAN: begin
          if (one_low) begin
            lrow_n  = rs;
            cnt_n   = CW'(1);
            state_n = DEBOUNCE;
          end else begin
            col_n = col_rot;
          end
        end
        DEBOUNCE: begin
          if (rs == lrow) begin
            cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
            if (cnt_n == CNT_MAX) begin
              state_n  = HELD;
              rcnt_n   = '0;
              accept_n = 1'b1;
            end
          end else begin
            cnt_n   = '0;
            col_n   = col_rot;
            state_n = SCAN;
          end
        end
        HELD: begin
          if (rs == 4'hF) begin
            rcnt_n = (rcnt == CNT_MAX) ? rcnt : rcnt + CW'(1);
            if (rcnt_n == CNT_MAX) begin
              state_n = SCAN;
              col_n   = col_rot;
              cnt_n   = '0;
              rcnt_n  = '0;
            end
          end else begin
            rcnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

  // Key decode from the latched row and the frozen column, one clk after acceptance.
  always_comb begin
    case (lrow)
      4'b1110: ri = 2'd0;
      4'b1101: ri = 2'd1;
      4'b1011: ri = 2'd2;
      default: ri = 2'd3;
    endcase
    case (col)
      4'b1110: ci = 2'd0;
      4'b1101: ci = 2'd1;
      4'b1011: ci = 2'd2;
      default: ci = 2'd3;
    endcase
    key_value_n = key_value;
    key_valid_n = 1'b0;
    start_n     = 1'b0;
    clear_n     = 1'b0;
    if (accept) begin
      if (ri == 2'd3) begin
        case (ci)
          2'd0:    clear_n = 1'b1;
          2'd1:    begin key_valid_n = 1'b1; key_value_n = 4'd0; end
          2'd2:    start_n = 1'b1;
          default: ;
        endcase
      end else if (ci != 2'd3) begin
        key_valid_n = 1'b1;
        key_value_n = {2'b00, ri} * 4'd3 + {2'b00, ci} + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
// Self-checking bench for keypad_scanner: a keypad model drives the rows from
// the column drive, and a scoreboard of expected key events is matched to pulses.
module tb_keypad_scanner;

  localparam int N = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row, col, key_value;
  logic        key_valid, start, clear;
  logic [15:0] pressed = '0;

  typedef struct {
    int kind;     // 0 digit, 1 start, 2 clear
    int value;
    int edge_at;  // expected clk edge of the pulse, -1 when not timed
  } ev_t;

  ev_t        sb[$];
  int         errors = 0;
  int         checks = 0;
  int         ecount;
  int         pulse_count = 0;
  logic [3:0] exp_kv = 4'd0;

  keypad_scanner #(.NUM_SCAN(N), .DEBOUNCE_SCANS(D)) dut (
    .clk(clk), .rst_n(rst), .row(row), .col(col), .key_value(key_value),
    .key_valid(key_valid), .start(start), .clear(clear)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign row[r] = ~|(pressed[r*4 +: 4] & ~col);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Pulse monitor: pops the scoreboard on every pulse and tracks key_value.
  always @(negedge clk) begin : monitor
    ev_t e;
    int  kind;
    if (key_valid || start || clear) begin
      pulse_count++;
      check("pulse_overlap", 32'(key_valid) + 32'(start) + 32'(clear), 1);
      if (sb.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        e    = sb.pop_front();
        kind = key_valid ? 0 : (start ? 1 : 2);
        check("event_kind", kind, e.kind);
        if (e.kind == 0) begin
          check("event_value", key_value, e.value);
          exp_kv = 4'(e.value);
        end
        if (e.edge_at >= 0) check("pulse_latency", ecount, e.edge_at);
      end
    end
    check("key_value_hold", key_value, exp_kv);
  end

  initial begin
    #2ms;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] col_at(input int e);
    return ~(4'b0001 << ((e / N) % 4));
  endfunction

  // First window-end edge after a press at edge p whose column is c.
  function automatic int first_sample(input int p, input int c);
    for (int s = N; s < 400; s += N)
      if ((((s / N) - 1) % 4) == c && s >= p + 3) return s;
    return -1;
  endfunction

  task automatic press(input int r, input int c);
    pressed[r*4 + c] = 1'b1;
  endtask

  task automatic release_key(input int r, input int c);
    pressed[r*4 + c] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check(tag, sb.size(), 0);
  endtask

  // Waits for the column drive to switch into target (bounded).
  task automatic wait_col(input string tag, input logic [3:0] target);
    int i;
    for (i = 0; i < 40 && col == target; i++) @(negedge clk);
    for (i = 0; i < 40 && col != target; i++) @(negedge clk);
    check(tag, col, target);
  endtask

  initial begin
    int         pc, p;
    logic [3:0] seen;

    idle(3);
    check("rst_col", col, 4'b1110);
    check("rst_key_value", key_value, 0);
    check("rst_pulses", {key_valid, start, clear}, 0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_col", col, col_at(ecount));
    end

    // Key 5 held steadily: one timed pulse, no repeats.
    p = ecount;
    sb.push_back('{0, 5, first_sample(p, 1) + (D - 1) * N + 1});
    press(1, 1);
    wait_drain("drain_key5", 60);
    pc = pulse_count;
    idle(200);
    check("key5_no_repeat", pulse_count, pc);
    release_key(1, 1);
    idle(30);

    // Key 1 with a bounce: first detection aborts, one pulse follows.
    wait_col("bounce_align", 4'b1110);
    press(0, 0);
    idle(N);
    check("bounce_detect_col", col, 4'b1110);
    release_key(0, 0);
    idle(N);
    pc = pulse_count;
    sb.push_back('{0, 1, -1});
    press(0, 0);
    wait_drain("drain_key1", 80);
    idle(20);
    check("key1_single_pulse", pulse_count, pc + 1);
    release_key(0, 0);
    idle(30);

    // '#', '*' and 'A'; key_value keeps 1 throughout.
    sb.push_back('{1, 0, -1});
    press(3, 2);
    wait_drain("drain_hash", 80);
    release_key(3, 2);
    idle(30);
    sb.push_back('{2, 0, -1});
    press(3, 0);
    wait_drain("drain_star", 80);
    release_key(3, 0);
    idle(30);
    pc = pulse_count;
    press(0, 3);
    idle(60);
    release_key(0, 3);
    idle(30);
    check("key_a_silent", pulse_count, pc);

    // Two rows low in column 0: no acceptance, columns keep rotating.
    pc = pulse_count;
    press(0, 0);
    press(1, 0);
    seen = 4'h0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      seen |= ~col;
    end
    check("multirow_rotate", seen, 4'hF);
    check("multirow_silent", pulse_count, pc);
    release_key(0, 0);
    release_key(1, 0);
    idle(30);

    // Key 0 with reset asserted mid-debounce.
    press(3, 1);
    wait_col("zero_align", 4'b1101);
    idle(N + 2);
    check("zero_frozen_col", col, 4'b1101);
    #1;
    rst    = 1'b1;
    exp_kv = 4'd0;
    #1;
    check("midrst_col", col, 4'b1110);
    check("midrst_key_value", key_value, 0);
    check("midrst_pulses", {key_valid, start, clear}, 0);
    release_key(3, 1);
    idle(3);
    rst = 1'b0;
    pc  = pulse_count;
    @(negedge clk);
    check("postrst_col", col, 4'b1110);
    idle(60);
    check("postrst_silent", pulse_count, pc);

    // 9 held, then 7 pressed alongside: only 9 reported; later 7 alone.
    sb.push_back('{0, 9, -1});
    press(2, 2);
    wait_drain("drain_nine", 80);
    pc = pulse_count;
    press(2, 0);
    idle(60);
    check("second_key_ignored", pulse_count, pc);
    release_key(2, 2);
    release_key(2, 0);
    idle(30);
    sb.push_back('{0, 7, -1});
    press(2, 0);
    wait_drain("drain_seven", 80);
    release_key(2, 0);
    idle(30);

    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
